// File: rtl/tron_steer_ctrl_if.sv
// Step-command bus from the steering controller to the X/Y position counters.
// Each axis gets an enable pulse (onoff) and a direction (pm, 1 = count up).
interface tron_steer_ctrl_if;
   logic x_onoff;
   logic x_pm;
   logic y_onoff;
   logic y_pm;

   // Steering controller drives the commands.
   modport master (
      output x_onoff,
      output x_pm,
      output y_onoff,
      output y_pm
   );

   // Position counters consume them.
   modport slave (
      input x_onoff,
      input x_pm,
      input y_onoff,
      input y_pm
   );
endinterface

// File: rtl/tron_steer_ctrl.sv
// Player steering controller for Tron-on-VGA.
// Turns left/right button presses into a 2-bit heading (0=N, 1=E, 2=S, 3=W) and
// emits one-cycle step pulses on the X or Y counter every TICK_DIV cycles while the
// player is alive. Owns the IDLE/RUN/DEAD round state for one player.
//
// Build option: define STEER_DEBOUNCE_EN to insert a DEB_CYCLES-sample debouncer
// between each button synchronizer and its edge detector.
module tron_steer_ctrl #(
   parameter int unsigned TICK_DIV     = 16,
   parameter logic [1:0]  HEADING_INIT = 2'd1,
   parameter int unsigned DEB_CYCLES   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_left,
   input  logic              btn_right,
   input  logic              start,
   input  logic              crash,
   tron_steer_ctrl_if.master cnt_if,
   output logic [1:0]        heading,
   output logic              alive
);

   localparam int unsigned    DivW    = $clog2(TICK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

   // Reject parameter sets the divider and debouncer cannot support.
   if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_param_check
      $error("tron_steer_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDead = 2'd2
   } state_e;

   state_e          state_q;
   logic            start_q;
   logic [DivW-1:0] div_q;
   logic            pend_q;
   logic            pend_cw_q;
   logic [1:0]      heading_q;
   logic            x_onoff_q;
   logic            x_pm_q;
   logic            y_onoff_q;
   logic            y_pm_q;
   logic            alive_q;

   // Button bit 0 = left, bit 1 = right throughout.
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;
   logic [1:0] lvl;
   logic [1:0] lvl_prev_q;
   logic [1:0] rise;
   logic       req_valid;
   logic       req_cw;
   logic       start_rise;
   logic       tick;
   logic [1:0] head_next;

   // Two-flop synchronizer for the asynchronous button levels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 2'b00;
         sync2_q <= 2'b00;
      end else begin
         sync1_q <= {btn_right, btn_left};
         sync2_q <= sync1_q;
      end
   end

`ifdef STEER_DEBOUNCE_EN
   localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);

   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DebW-1:0] cnt_q;
      logic            lvl_q;

      // Flip the debounced level only after DEB_CYCLES consecutive differing samples.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
         end else if (sync2_q[i] == lvl_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DebW'(DEB_CYCLES - 1)) begin
            cnt_q <= '0;
            lvl_q <= sync2_q[i];
         end else begin
            cnt_q <= cnt_q + DebW'(1);
         end
      end

      assign lvl[i] = lvl_q;
   end
`else
   assign lvl = sync2_q;
`endif

   // Previous button level for rising-edge detection; a held button turns once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_prev_q <= 2'b00;
      end else begin
         lvl_prev_q <= lvl;
      end
   end

   assign rise       = lvl & ~lvl_prev_q;
   // Simultaneous left and right edges cancel.
   assign req_valid  = rise[0] ^ rise[1];
   assign req_cw     = rise[1];
   assign start_rise = start & ~start_q;
   assign tick       = (div_q == DivLast);

   // Heading after applying any pending turn; used in the tick cycle itself.
   always_comb begin
      head_next = heading_q;
      if (pend_q) begin
         head_next = pend_cw_q ? heading_q + 2'd1 : heading_q - 2'd1;
      end
   end

   // Round FSM with divider, pending turn and registered step outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         start_q   <= 1'b0;
         div_q     <= '0;
         pend_q    <= 1'b0;
         pend_cw_q <= 1'b0;
         heading_q <= HEADING_INIT;
         x_onoff_q <= 1'b0;
         x_pm_q    <= 1'b1;
         y_onoff_q <= 1'b0;
         y_pm_q    <= 1'b0;
         alive_q   <= 1'b0;
      end else begin
         start_q   <= start;
         x_onoff_q <= 1'b0;
         y_onoff_q <= 1'b0;
         unique case (state_q)
            StIdle, StDead: begin
               if (start_rise) begin
                  state_q   <= StRun;
                  heading_q <= HEADING_INIT;
                  div_q     <= '0;
                  pend_q    <= 1'b0;
                  alive_q   <= 1'b1;
               end
            end
            StRun: begin
               if (crash) begin
                  // Crash wins over a coincident tick: no step is emitted.
                  state_q <= StDead;
                  alive_q <= 1'b0;
                  pend_q  <= 1'b0;
               end else if (tick) begin
                  div_q     <= '0;
                  heading_q <= head_next;
                  // A request arriving in the tick cycle opens the next period.
                  pend_q    <= req_valid;
                  pend_cw_q <= req_cw;
                  unique case (head_next)
                     2'd0: begin
                        y_onoff_q <= 1'b1;
                        y_pm_q    <= 1'b0;
                     end
                     2'd1: begin
                        x_onoff_q <= 1'b1;
                        x_pm_q    <= 1'b1;
                     end
                     2'd2: begin
                        y_onoff_q <= 1'b1;
                        y_pm_q    <= 1'b1;
                     end
                     default: begin
                        x_onoff_q <= 1'b1;
                        x_pm_q    <= 1'b0;
                     end
                  endcase
               end else begin
                  div_q <= div_q + DivW'(1);
                  // First request in a tick period wins; later ones are dropped.
                  if (!pend_q && req_valid) begin
                     pend_q    <= 1'b1;
                     pend_cw_q <= req_cw;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               alive_q <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_if.x_onoff = x_onoff_q;
   assign cnt_if.x_pm    = x_pm_q;
   assign cnt_if.y_onoff = y_onoff_q;
   assign cnt_if.y_pm    = y_pm_q;
   assign heading        = heading_q;
   assign alive          = alive_q;

endmodule

// File: doc/tron_steer_ctrl.md
# tron_steer_ctrl

Player steering controller for the Tron-on-VGA game: converts left/right turn buttons into a heading state and emits the per-axis `onoff`/`pm` step commands that drive the X and Y position counters (10-bit up/down counters enabled by `onoff`, counting up when `pm`=1). It is the command-side master of that counter interface. It sits between the button inputs and the player's two position counters and owns the run/dead game state for one player.

## Interface
- `TICK_DIV`, 16: clock cycles per movement step (≥2).
- `HEADING_INIT`, 2'd1: heading loaded on start (0=N, 1=E, 2=S, 3=W).
- `DEB_CYCLES`, 8: stable-sample count for debounce (only used with `STEER_DEBOUNCE_EN`).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_left` in 1: turn counter-clockwise, asynchronous level.
- `btn_right` in 1: turn clockwise, asynchronous level.
- `start` in 1: synchronous level; rising edge starts or restarts a round.
- `crash` in 1: synchronous collision flag from the trail/collision logic.
- `x_onoff` out 1: X counter step enable pulse.
- `x_pm` out 1: X direction (1=+, 0=−).
- `y_onoff` out 1: Y counter step enable pulse.
- `y_pm` out 1: Y direction (1=+ i.e. down-screen, 0=−).
- `heading` out 2: current heading.
- `alive` out 1: high in RUN.

## Operation
- FSM states: IDLE, RUN, DEAD. Reset → IDLE.
- IDLE: no steps. A `start` rising edge (registered previous value 0, current 1) → RUN; heading ← `HEADING_INIT`; divider ← 0; pending turn cleared.
- RUN: the divider counts 0..`TICK_DIV`−1 and wraps; a tick occurs when the divider equals `TICK_DIV`−1.
- On a tick, exactly one axis steps for one cycle: N → `y_onoff`=1, `y_pm`=0; S → `y_onoff`=1, `y_pm`=1; E → `x_onoff`=1, `x_pm`=1; W → `x_onoff`=1, `x_pm`=0. The other axis keeps `onoff`=0.
- `pm` outputs are held at the last stepped direction between pulses. They are only meaningful when the matching `onoff` is 1.
- Buttons pass through a 2-flop synchronizer and then rising-edge detection.
  - A left edge requests heading−1 mod 4; a right edge requests heading+1 mod 4.
  - Left and right edges in the same cycle cancel, giving no request.
- At most one turn is pending per tick period. The first request is latched and later requests are ignored until the next tick.
- The pending turn is applied to `heading` in the tick cycle itself, so the step emitted on that tick already uses the new heading. The pending turn is then cleared.
- A held button produces one turn only.
- `crash`=1 in RUN → DEAD on the next edge. The step pulse is suppressed in that cycle if it coincides with a tick.
- DEAD: no steps; `heading` is frozen. A `start` rising edge → RUN with the same initialisation as from IDLE.
- `crash` is ignored outside RUN. `start` edges are ignored in RUN.

## Timing
- Reset values: `x_onoff`=`y_onoff`=0, `x_pm`=1, `y_pm`=0, `heading`=`HEADING_INIT`, `alive`=0, divider=0, synchronizers=0, pending=0.
- Reset mid-round: all outputs return to reset values immediately (asynchronous). State becomes IDLE.
- All outputs are registered. An `onoff` pulse is exactly 1 cycle wide, asserted the cycle after the divider reads `TICK_DIV`−1.
- First step: `TICK_DIV`+1 cycles after the cycle in which `start` is sampled high in IDLE/DEAD. Subsequent steps follow every `TICK_DIV` cycles.
- `alive` rises 1 cycle after the `start` edge and falls 1 cycle after `crash` is sampled.
- Button-to-pending latency: 3 cycles without debounce (2 sync + edge).

## Configuration
- `STEER_DEBOUNCE_EN` defined:
  - Each synchronized button feeds a debouncer. The debounced level changes only after `DEB_CYCLES` consecutive equal samples.
  - Edge detection runs on the debounced level.
  - Button-to-pending latency is 3+`DEB_CYCLES` cycles.
  - Glitches shorter than `DEB_CYCLES` are rejected.
- Not defined: no debouncer; edge detection runs directly on the synchronizer output. `DEB_CYCLES` is unused.

## Test plan
- Reset, then a `start` pulse with `TICK_DIV`=16 → first `x_onoff` pulse at cycle 17 after start with `x_pm`=1; pulses repeat every 16 cycles; `y_onoff` stays 0.
- `btn_right` held 40 cycles in RUN, heading E → heading=S (2) at the next tick; that tick gives `y_onoff`=1, `y_pm`=1; no further turns while the button is held.
- Left and right pressed in the same cycle → heading unchanged. Separately, left then right within one tick period → only the left turn is applied (E→N, `y_pm`=0).
- `crash` asserted in the cycle the divider reads 15 → no step pulse; `alive`=0 next cycle; no pulses for 100 cycles; a later `start` edge → heading=E, steps resume after 17 cycles.
- `reset` asserted mid-RUN between edges → outputs immediately return to reset values and the state is IDLE; `start` is required to resume.
- With `STEER_DEBOUNCE_EN` and `DEB_CYCLES`=8 → a 5-cycle `btn_left` glitch produces no turn; a 12-cycle press produces exactly one turn.
